border_alert_ctrl: RTL and testbench

BORDER_ALERT_CTRL -- requirements
Module: border_alert_ctrl

---
 rtl/border_alert_ctrl.sv | 76 +++++++
 tb/tb_border_alert_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/border_alert_ctrl.sv
// border_alert_ctrl: timed blink sequencer that composites a flashing red band
// just inside the black outer frame of a 96x64 RGB565 OLED raster.
module border_alert_ctrl #(
    parameter int BLINK_TICKS = 6250000,
    parameter int BLINKS      = 3,
    parameter int BORDER_W    = 3
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        trigger,
    input  logic [12:0] pixel_index,
    input  logic [15:0] bg_color,
    output logic [15:0] color,
    output logic        busy,
    output logic        blink_on
);
    localparam int TW = $clog2(BLINK_TICKS);
    localparam int BW = $clog2(BLINKS + 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [BW-1:0] blink, blink_n;
    logic          last, final_pair;
    int            x, y;
    logic          frame, band;
    logic [15:0]   color_n;

    always_ff @(posedge clk25 or posedge rst)
        if (rst) begin
            state <= IDLE;
            tick  <= '0;
            blink <= '0;
            color <= '0;
        end else begin
            state <= state_n;
            tick  <= tick_n;
            blink <= blink_n;
            color <= color_n;
        end

    assign last       = tick == TW'(BLINK_TICKS - 1);
    assign final_pair = blink == BW'(BLINKS - 1);

    // A trigger always wins, including over the last OFF expiry.
    always_comb begin
        state_n = state;
        tick_n  = tick;
        blink_n = blink;
        if (trigger) begin
            state_n = ON;
            tick_n  = '0;
            blink_n = '0;
        end else if (state != IDLE) begin
            tick_n = last ? '0 : tick + TW'(1);
            if (last && state == ON)
                state_n = OFF;
            else if (last) begin
                state_n = final_pair ? IDLE : ON;
                blink_n = final_pair ? '0 : blink + BW'(1);
            end
        end
    end

    assign busy     = state != IDLE;
    assign blink_on = state == ON;

    assign x     = int'(pixel_index) % 96;
    assign y     = int'(pixel_index) / 96;
    assign frame = x < 4 || x > 91 || y < 4 || y > 59;
    assign band  = x < 4 + BORDER_W || x > 91 - BORDER_W || y < 4 + BORDER_W || y > 59 - BORDER_W;

    assign color_n = (pixel_index >= 13'd6144 || frame) ? 16'h0000 :
                     (band && blink_on) ? 16'hF800 : bg_color;
endmodule

// File: tb/tb_border_alert_ctrl.sv
// tb_border_alert_ctrl: table vectors, directed corner sequences and random
// stimulus checked against an elapsed-time model of the alert.
module tb_border_alert_ctrl;
    localparam int T     = 4;
    localparam int B     = 2;
    localparam int TOTAL = 2 * T * B;

    typedef struct packed {
        logic        trig;
        logic [12:0] idx;
        logic [15:0] bg;
        logic [15:0] exp;
    } pix_vec_t;

    typedef struct packed {
        logic busy;
        logic blink;
    } alert_vec_t;

    logic        clk25 = 1'b0;
    logic        rst, trigger;
    logic [12:0] pixel_index;
    logic [15:0] bg_color, color;
    logic        busy, blink_on;

    int checks = 0;
    int errors = 0;
    bit m_active = 1'b0;
    int m_age = 0;

    pix_vec_t   pv[15];
    alert_vec_t av[17];

    always #5 clk25 = ~clk25;

    border_alert_ctrl #(.BLINK_TICKS(T), .BLINKS(B), .BORDER_W(3)) dut (
        .clk25      (clk25),
        .rst        (rst),
        .trigger    (trigger),
        .pixel_index(pixel_index),
        .bg_color   (bg_color),
        .color      (color),
        .busy       (busy),
        .blink_on   (blink_on)
    );

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Alert modelled as elapsed cycles since the last trigger; ON in even quarter-phases.
    function automatic logic m_blink();
        return m_active && ((m_age / T) % 2 == 0);
    endfunction

    function automatic logic [15:0] pix_ref(input int idx, input logic [15:0] bg, input logic bl);
        int px;
        int py;
        px = idx % 96;
        py = idx / 96;
        if (idx >= 6144 || px < 4 || px > 91 || py < 4 || py > 59) return 16'h0000;
        if (bl && (px < 7 || px > 88 || py < 7 || py > 56)) return 16'hF800;
        return bg;
    endfunction

    task automatic step();
        logic [15:0] exp_c;
        exp_c = rst ? 16'h0000 : pix_ref(int'(pixel_index), bg_color, m_blink());
        @(posedge clk25);
        if (rst) m_active = 1'b0;
        else if (trigger) begin
            m_active = 1'b1;
            m_age    = 0;
        end else if (m_active) begin
            m_age++;
            if (m_age >= TOTAL) m_active = 1'b0;
        end
        #1;
        chk("color", color, exp_c);
        chk("busy", 16'(busy), 16'(m_active));
        chk("blink_on", 16'(blink_on), 16'(m_blink()));
    endtask

    initial begin
        int n;
        pv = '{
            '{1'b1, 13'd388,  16'h001F, 16'h001F},
            '{1'b1, 13'd0,    16'h07E0, 16'h0000},
            '{1'b1, 13'd388,  16'h07E0, 16'hF800},
            '{1'b1, 13'd970,  16'h07E0, 16'h07E0},
            '{1'b1, 13'd95,   16'h07E0, 16'h0000},
            '{1'b1, 13'd6144, 16'h07E0, 16'h0000},
            '{1'b1, 13'd966,  16'h07E0, 16'hF800},
            '{1'b1, 13'd967,  16'h07E0, 16'h07E0},
            '{1'b1, 13'd1049, 16'h07E0, 16'hF800},
            '{1'b1, 13'd1048, 16'h07E0, 16'h07E0},
            '{1'b1, 13'd5482, 16'h07E0, 16'hF800},
            '{1'b1, 13'd5386, 16'h07E0, 16'h07E0},
            '{1'b1, 13'd5770, 16'h07E0, 16'h0000},
            '{1'b1, 13'd1052, 16'h07E0, 16'h0000},
            '{1'b1, 13'd6143, 16'h07E0, 16'h0000}
        };
        av = '{
            '{1'b1, 1'b1}, '{1'b1, 1'b1}, '{1'b1, 1'b1}, '{1'b1, 1'b1},
            '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0},
            '{1'b1, 1'b1}, '{1'b1, 1'b1}, '{1'b1, 1'b1}, '{1'b1, 1'b1},
            '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0},
            '{1'b0, 1'b0}
        };

        rst = 1'b1;
        trigger = 1'b0;
        pixel_index = 13'd0;
        bg_color = 16'hFFFF;
        #1;
        chk("reset_color", color, 16'h0000);
        chk("reset_busy", 16'(busy), 16'h0);
        chk("reset_blink", 16'(blink_on), 16'h0);
        step();
        step();
        rst = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 15; i++) begin
            trigger = pv[i].trig;
            pixel_index = pv[i].idx;
            bg_color = pv[i].bg;
            step();
            chk($sformatf("pix_%0d", pv[i].idx), color, pv[i].exp);
        end
        trigger = 1'b0;
        repeat (20) step();

        pixel_index = 13'd388;
        bg_color = 16'h07E0;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("alert_busy_0", 16'(busy), 16'(av[0].busy));
        chk("alert_blink_0", 16'(blink_on), 16'(av[0].blink));
        for (int i = 1; i < 17; i++) begin
            step();
            chk($sformatf("alert_busy_%0d", i), 16'(busy), 16'(av[i].busy));
            chk($sformatf("alert_blink_%0d", i), 16'(blink_on), 16'(av[i].blink));
        end

        trigger = 1'b1;
        step();
        trigger = 1'b0;
        repeat (10) step();
        chk("second_on_tick2", 16'(blink_on), 16'h1);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("restart_on", 16'(blink_on), 16'h1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!busy) break;
            n++;
        end
        chk("restart_len", 16'(n), 16'(TOTAL));

        trigger = 1'b1;
        step();
        trigger = 1'b0;
        repeat (15) step();
        chk("final_off_busy", 16'(busy), 16'h1);
        chk("final_off_blink", 16'(blink_on), 16'h0);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("simul_busy", 16'(busy), 16'h1);
        chk("simul_blink", 16'(blink_on), 16'h1);
        repeat (16) step();
        chk("simul_end", 16'(busy), 16'h0);

        trigger = 1'b1;
        step();
        trigger = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("async_busy", 16'(busy), 16'h0);
        chk("async_blink", 16'(blink_on), 16'h0);
        chk("async_color", color, 16'h0000);
        m_active = 1'b0;
        #1 rst = 1'b0;
        repeat (8) step();
        chk("no_resume", 16'(busy), 16'h0);

        rst = 1'b1;
        trigger = 1'b1;
        step();
        chk("trig_in_reset", 16'(busy), 16'h0);
        rst = 1'b0;
        step();
        chk("trig_after_release", 16'(busy), 16'h1);
        trigger = 1'b0;

        repeat (400) begin
            trigger = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            pixel_index = 13'($urandom_range(0, 8191));
            bg_color = 16'($urandom);
            step();
        end
        rst = 1'b0;
        trigger = 1'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
